// File: rtl/aes_wddl_pkg.sv
// -----------------------------------------------------------------------------
// aes_wddl_pkg
// Shared definitions for the WDDL AddRoundKey pipeline stage:
//   - wddl_state_e      : precharge / idle / evaluate FSM encoding
//   - PRE_CNT_W         : width of the precharge cycle counter
//   - pre_cycles_legal  : legality check for the PRE_CYCLES parameter (1..15)
//   - nbytes_legal      : legality check for the NBYTES parameter (1..16)
// No ports (package).
// -----------------------------------------------------------------------------
package aes_wddl_pkg;

   typedef enum logic [1:0] {
      ST_PRE  = 2'd0,
      ST_IDLE = 2'd1,
      ST_EVAL = 2'd2
   } wddl_state_e;

   // Four bits cover the whole legal PRE_CYCLES range, so the counter never wraps.
   localparam int PRE_CNT_W = 4;

   function automatic bit pre_cycles_legal(input int pre_cycles);
      return (pre_cycles >= 32'sd1) && (pre_cycles <= 32'sd15);
   endfunction

   function automatic bit nbytes_legal(input int nbytes);
      return (nbytes >= 32'sd1) && (nbytes <= 32'sd16);
   endfunction

endpackage

// File: rtl/aes_wddl_rail_chk.sv
// -----------------------------------------------------------------------------
// aes_wddl_rail_chk
// Sticky rail-fault detector for a WDDL dual-rail bus.
//   eval=1 : fault if any bit has rail_t == rail_f (not complementary)
//   eval=0 : fault if any rail bit is 1 (precharge must be all zero)
// A fault sets alarm at the next rising edge; alarm holds until reset.
// Ports:
//   clk     in  1  rising-edge clock
//   rst_n   in  1  asynchronous active-low reset
//   eval    in  1  bus is in its evaluate phase
//   rail_t  in  W  true rail
//   rail_f  in  W  false rail
//   alarm   out 1  sticky fault flag
// -----------------------------------------------------------------------------
module aes_wddl_rail_chk #(
   parameter int W = 128
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         eval,
   input  logic [W-1:0] rail_t,
   input  logic [W-1:0] rail_f,
   output logic         alarm
);

   logic fault_s;
   logic alarm_r;

   // Phase-dependent rail fault detection.
   always_comb begin
      fault_s = 1'b0;
      if (eval) begin
         fault_s = |(~(rail_t ^ rail_f));
      end else begin
         fault_s = |(rail_t | rail_f);
      end
   end

   // Sticky alarm register, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alarm_r <= 1'b0;
      end else begin
         alarm_r <= alarm_r | fault_s;
      end
   end

   assign alarm = alarm_r;

endmodule

// File: rtl/wddl_xor2.sv
// -----------------------------------------------------------------------------
// wddl_xor2
// WDDL dual-rail XOR built only from AND/OR terms so that an all-zero
// (precharge) input yields an all-zero output on both rails.
// Ports:
//   a, a_n   in  W  operand A, true / false rail
//   b, b_n   in  W  operand B, true / false rail
//   y, y_n   out W  result, true / false rail (exact complement for valid inputs)
// -----------------------------------------------------------------------------
module wddl_xor2 #(
   parameter int W = 128
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] a_n,
   input  logic [W-1:0] b,
   input  logic [W-1:0] b_n,
   output logic [W-1:0] y,
   output logic [W-1:0] y_n
);

   // Monotone positive-logic XOR / XNOR pair.
   assign y   = (a & b_n) | (a_n & b);
   assign y_n = (a & b)   | (a_n & b_n);

endmodule

// File: rtl/aes_addroundkey_wddl_pipe.sv
// -----------------------------------------------------------------------------
// aes_addroundkey_wddl_pipe
// WDDL dual-rail AddRoundKey stage with a precharge/evaluate FSM and
// valid/ready handshakes on both sides. Between successive results both output
// rails are forced to zero for PRE_CYCLES cycles.
//   ld_r=1 : result = text_in XOR w_i (dual-rail)
//   ld_r=0 : result = sa_i / sa_i_n passthrough
// Optional feature macro: AES_WDDL_ALARM_EN (enables the sticky rail checker;
// otherwise alarm is tied to 0).
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    input handshake (in_ready high only in IDLE)
//   ld_r                   source select, sampled on the input handshake
//   text_in, text_in_n     plaintext rails          (W = 8*NBYTES)
//   w_i, w_i_n             round key rails
//   sa_i, sa_i_n           state feedback rails
//   sa_o, sa_o_n           result rails, zero while not evaluating
//   out_valid / out_ready  output handshake
//   alarm                  sticky rail-fault flag
// -----------------------------------------------------------------------------
module aes_addroundkey_wddl_pipe
   import aes_wddl_pkg::*;
#(
   parameter int NBYTES     = 16,
   parameter int PRE_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                ld_r,
   input  logic [8*NBYTES-1:0] text_in,
   input  logic [8*NBYTES-1:0] text_in_n,
   input  logic [8*NBYTES-1:0] w_i,
   input  logic [8*NBYTES-1:0] w_i_n,
   input  logic [8*NBYTES-1:0] sa_i,
   input  logic [8*NBYTES-1:0] sa_i_n,
   output logic [8*NBYTES-1:0] sa_o,
   output logic [8*NBYTES-1:0] sa_o_n,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                alarm
);

   localparam int W = 8 * NBYTES;
   localparam logic [PRE_CNT_W-1:0] CNT_RELOAD = PRE_CNT_W'(PRE_CYCLES);
   localparam logic [PRE_CNT_W-1:0] CNT_ONE    = PRE_CNT_W'(1);
   localparam logic [W-1:0]         RAIL_ZERO  = '0;

   if (!pre_cycles_legal(PRE_CYCLES) || !nbytes_legal(NBYTES)) begin : g_bad_param
      $error("aes_addroundkey_wddl_pipe: NBYTES must be 1..16 and PRE_CYCLES 1..15");
   end

   wddl_state_e          state_r;
   wddl_state_e          state_nxt_s;
   logic [PRE_CNT_W-1:0] cnt_r;
   logic [PRE_CNT_W-1:0] cnt_nxt_s;
   logic [W-1:0]         sa_r;
   logic [W-1:0]         sa_n_r;
   logic [W-1:0]         sa_nxt_s;
   logic [W-1:0]         sa_n_nxt_s;
   logic                 out_valid_r;
   logic                 out_valid_nxt_s;
   logic                 in_ready_r;
   logic                 in_ready_nxt_s;
   logic [W-1:0]         xor_t_s;
   logic [W-1:0]         xor_f_s;
   logic [W-1:0]         sel_t_s;
   logic [W-1:0]         sel_f_s;

   wddl_xor2 #(.W(W)) u_xor (
      .a   (text_in),
      .a_n (text_in_n),
      .b   (w_i),
      .b_n (w_i_n),
      .y   (xor_t_s),
      .y_n (xor_f_s)
   );

   // Source select; no rail correction, non-complementary inputs pass as-is.
   always_comb begin
      if (ld_r) begin
         sel_t_s = xor_t_s;
         sel_f_s = xor_f_s;
      end else begin
         sel_t_s = sa_i;
         sel_f_s = sa_i_n;
      end
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_PRE;
         cnt_r       <= CNT_RELOAD;
         sa_r        <= RAIL_ZERO;
         sa_n_r      <= RAIL_ZERO;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         sa_r        <= sa_nxt_s;
         sa_n_r      <= sa_n_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         in_ready_r  <= in_ready_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_PRE: begin
            // Leaving at count 1 gives exactly PRE_CYCLES cycles in PRE.
            if (cnt_r <= CNT_ONE) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_PRE;
            end
         end
         ST_IDLE: begin
            if (in_valid) begin
               state_nxt_s = ST_EVAL;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_EVAL: begin
            if (out_ready) begin
               state_nxt_s = ST_PRE;
            end else begin
               state_nxt_s = ST_EVAL;
            end
         end
         default: begin
            state_nxt_s = ST_PRE;
         end
      endcase
   end

   // Next values of the counter and the registered outputs.
   always_comb begin
      cnt_nxt_s       = cnt_r;
      sa_nxt_s        = RAIL_ZERO;
      sa_n_nxt_s      = RAIL_ZERO;
      out_valid_nxt_s = 1'b0;
      in_ready_nxt_s  = 1'b0;
      case (state_r)
         ST_PRE: begin
            if (cnt_r <= CNT_ONE) begin
               in_ready_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s      = cnt_r - CNT_ONE;
               in_ready_nxt_s = 1'b0;
            end
         end
         ST_IDLE: begin
            if (in_valid) begin
               sa_nxt_s        = sel_t_s;
               sa_n_nxt_s      = sel_f_s;
               out_valid_nxt_s = 1'b1;
            end else begin
               in_ready_nxt_s  = 1'b1;
            end
         end
         ST_EVAL: begin
            // An in_valid arriving here is ignored; it waits for IDLE.
            if (out_ready) begin
               cnt_nxt_s       = CNT_RELOAD;
            end else begin
               sa_nxt_s        = sa_r;
               sa_n_nxt_s      = sa_n_r;
               out_valid_nxt_s = 1'b1;
            end
         end
         default: begin
            cnt_nxt_s = CNT_RELOAD;
         end
      endcase
   end

   assign sa_o      = sa_r;
   assign sa_o_n    = sa_n_r;
   assign out_valid = out_valid_r;
   assign in_ready  = in_ready_r;

`ifdef AES_WDDL_ALARM_EN
   aes_wddl_rail_chk #(.W(W)) u_rail_chk (
      .clk    (clk),
      .rst_n  (rst_n),
      .eval   (out_valid_r),
      .rail_t (sa_r),
      .rail_f (sa_n_r),
      .alarm  (alarm)
   );
`else
   assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_aes_addroundkey_wddl_pipe.sv
// -----------------------------------------------------------------------------
// tb_aes_addroundkey_wddl_pipe
// Scoreboard bench: results expected from the main instance (PRE_CYCLES=1) are
// queued as stimulus is issued and popped by a monitor on each output
// handshake. A second instance (PRE_CYCLES=3) checks accept spacing.
// -----------------------------------------------------------------------------
module tb_aes_addroundkey_wddl_pipe;

   localparam int W = 128;

`ifdef AES_WDDL_ALARM_EN
   localparam logic ALARM_EXP = 1'b1;
`else
   localparam logic ALARM_EXP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         in_valid, in_ready, ld_r, out_valid, out_ready, alarm;
   logic [W-1:0] text_in, text_in_n, w_i, w_i_n, sa_i, sa_i_n, sa_o, sa_o_n;

   logic         in_valid_b, in_ready_b, ld_r_b, out_valid_b, out_ready_b, alarm_b;
   logic [W-1:0] text_b, text_n_b, w_b, w_n_b, sa_i_b, sa_i_n_b, sa_o_b, sa_o_n_b;

   int checks = 0;
   int errors = 0;
   logic [2*W-1:0] exp_q[$];

   aes_addroundkey_wddl_pipe #(.NBYTES(16), .PRE_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ld_r(ld_r),
      .text_in(text_in), .text_in_n(text_in_n), .w_i(w_i), .w_i_n(w_i_n),
      .sa_i(sa_i), .sa_i_n(sa_i_n), .sa_o(sa_o), .sa_o_n(sa_o_n),
      .out_valid(out_valid), .out_ready(out_ready), .alarm(alarm)
   );

   aes_addroundkey_wddl_pipe #(.NBYTES(16), .PRE_CYCLES(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .ld_r(ld_r_b),
      .text_in(text_b), .text_in_n(text_n_b), .w_i(w_b), .w_i_n(w_n_b),
      .sa_i(sa_i_b), .sa_i_n(sa_i_n_b), .sa_o(sa_o_b), .sa_o_n(sa_o_n_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .alarm(alarm_b)
   );

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: compare each consumed result with the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual=%h required=none", {sa_o, sa_o_n});
         end else begin
            chk("sb_result", {sa_o, sa_o_n}, exp_q.pop_front());
         end
      end
   end

   // Issue one word on the main instance and queue its expected result.
   task automatic send_a(input logic ld, input logic [W-1:0] t, input logic [W-1:0] tn,
                         input logic [W-1:0] k, input logic [W-1:0] kn,
                         input logic [W-1:0] s, input logic [W-1:0] sn,
                         input logic [2*W-1:0] exp);
      int n;
      @(posedge clk); #1;
      ld_r = ld; text_in = t; text_in_n = tn; w_i = k; w_i_n = kn; sa_i = s; sa_i_n = sn;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      end else begin
         exp_q.push_back(exp);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] fips_t, fips_k, fips_r, a5, h11, h22, h33;
      int acc_n[$];

      fips_t = 128'h00112233445566778899aabbccddeeff;
      fips_k = 128'h000102030405060708090a0b0c0d0e0f;
      fips_r = 128'h00102030405060708090a0b0c0d0e0f0;
      a5     = {16{8'hA5}};
      h11    = {16{8'h11}};
      h22    = {16{8'h22}};
      h33    = {16{8'h33}};

      rst_n = 1'b0; in_valid = 1'b0; ld_r = 1'b0; out_ready = 1'b1;
      text_in = '0; text_in_n = '0; w_i = '0; w_i_n = '0; sa_i = '0; sa_i_n = '0;
      in_valid_b = 1'b0; ld_r_b = 1'b1; out_ready_b = 1'b1;
      text_b = h11; text_n_b = ~h11; w_b = h22; w_n_b = ~h22; sa_i_b = '0; sa_i_n_b = '0;

      // 1. Reset state and release.
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_rails", {sa_o, sa_o_n}, 0);
      chk("rst_alarm", alarm, 0);
      rst_n = 1'b1;
      #1 chk("rel_in_ready_low", in_ready, 0);
      @(negedge clk);
      chk("rel_in_ready_high", in_ready, 1);
      chk("rel_rails", {sa_o, sa_o_n}, 0);

      // 2. FIPS-197 round-0 AddRoundKey.
      send_a(1'b1, fips_t, ~fips_t, fips_k, ~fips_k, '0, '0, {fips_r, ~fips_r});
      @(negedge clk);
      chk("fips_out_valid", out_valid, 1);
      @(negedge clk);

      // 3. Passthrough held by back-pressure, then exact precharge length.
      out_ready = 1'b0;
      send_a(1'b0, '0, '0, '0, '0, a5, ~a5, {a5, ~a5});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_data", {sa_o, sa_o_n}, {a5, ~a5});
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rails", {sa_o, sa_o_n}, 0);
      chk("pre_in_ready", in_ready, 0);
      chk("pre_out_valid", out_valid, 0);
      @(negedge clk);
      chk("pre_done_in_ready", in_ready, 1);
      chk("idle_rails", {sa_o, sa_o_n}, 0);

      // 4. Back-to-back on the PRE_CYCLES=3 instance.
      @(posedge clk); #1 in_valid_b = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (in_ready_b === 1'b1) acc_n.push_back(n);
         if (out_valid_b === 1'b1) begin
            chk("b2b_data", {sa_o_b, sa_o_n_b}, {h33, ~h33});
         end else begin
            chk("b2b_gap_rails", {sa_o_b, sa_o_n_b}, 0);
         end
      end
      in_valid_b = 1'b0;
      chk("b2b_accepts", (acc_n.size() >= 3) ? 1 : 0, 1);
      for (int i = 1; i < acc_n.size(); i++) begin
         chk("b2b_spacing", acc_n[i] - acc_n[i-1], 5);
      end

      // 5. Asynchronous reset during EVAL.
      out_ready = 1'b0;
      send_a(1'b0, '0, '0, '0, '0, h11, ~h11, {h11, ~h11});
      @(negedge clk);
      chk("areset_pre_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_rails", {sa_o, sa_o_n}, 0);
      chk("areset_valid", out_valid, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("areset_recover", in_ready, 1);

      // 6. Rail fault on bit 0: both rails high.
      out_ready = 1'b0;
      send_a(1'b1, 128'h1, {W{1'b1}}, '0, {W{1'b1}}, '0, '0, {128'h1, {W{1'b1}}});
      @(negedge clk);
      chk("alarm_eval_entry", alarm, 0);
      @(negedge clk);
      chk("alarm_set", alarm, ALARM_EXP);
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("alarm_sticky_pre", alarm, ALARM_EXP);
      @(negedge clk);
      chk("alarm_sticky_idle", alarm, ALARM_EXP);
      rst_n = 1'b0;
      #1 chk("alarm_reset", alarm, 0);
      @(negedge clk);
      rst_n = 1'b1;

      chk("sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
